// File: rtl/ram_arb_pkg.sv
// Shared constants and FSM state type for the two-port 8x16 RAM access controller.
package ram_arb_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational pick, registered priority pointer.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] req,
   input  logic       enable,
   input  logic       update,
   input  logic       upd_idx,
   output logic [1:0] grant,
   output logic       winner
);

   logic ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (update) begin
         ptr_d = upd_idx;
      end
   end

   // Pointer holds the last winner; on a tie the other requester goes next.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      grant  = '0;
      winner = 1'b0;
      if (enable) begin
         case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~ptr_q;
            default: winner = 1'b0;
         endcase
         if (req != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
         end
      end
   end

endmodule

// File: rtl/ram_8x16_arbiter.sv
// Round-robin controller sharing one 8x16 RAM between two req/ack requesters.
module ram_8x16_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned DATA_W = ram_arb_pkg::DATA_W,
   parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   state_e            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              ram_rw_q, ram_rw_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [1:0]        arb_grant;
   logic              arb_winner;
   logic              ptr_upd;

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .clr     (clr),
      .req     ({req1, req0}),
      .enable  (state_q == IDLE),
      .update  (ptr_upd),
      .upd_idx (gnt_q[1]),
      .grant   (arb_grant),
      .winner  (arb_winner)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      ram_rw_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      rdata_d    = rdata_q;
      ptr_upd    = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_grant != 2'b00) begin
               gnt_d      = arb_grant;
               ram_addr_d = arb_winner ? addr1  : addr0;
               ram_din_d  = arb_winner ? wdata1 : wdata0;
               ram_rw_d   = arb_winner ? we1    : we0;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (!ram_rw_q) begin
               rdata_d = ram_dout;
            end
            ack0_d  = gnt_q[0];
            ack1_d  = gnt_q[1];
            ptr_upd = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         ram_rw_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         ram_rw_q   <= ram_rw_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         rdata_q    <= rdata_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign gnt      = gnt_q;
   assign busy     = (state_q != IDLE);
   assign ram_rw   = ram_rw_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram_8x16_arbiter.sv
// Bench for ram_8x16_arbiter: bench-side RAM, transaction-timeline model, per-cycle compare.
module tb_ram_8x16_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          rq    [2];
   logic          rwe   [2];
   logic [AW-1:0] raddr [2];
   logic [DW-1:0] rwd   [2];

   logic          req0, we0, req1, we1, ack0, ack1, busy, ram_rw;
   logic [AW-1:0] addr0, addr1, ram_addr;
   logic [DW-1:0] wdata0, wdata1, rdata, ram_din, ram_dout;
   logic [1:0]    gnt;

   logic [DW-1:0] ram [8];

   int n_tests = 0;
   int n_fail  = 0;

   assign req0 = rq[0];  assign we0 = rwe[0];  assign addr0 = raddr[0];  assign wdata0 = rwd[0];
   assign req1 = rq[1];  assign we1 = rwe[1];  assign addr1 = raddr[1];  assign wdata1 = rwd[1];

   ram_8x16_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .clr(clr),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .gnt(gnt), .busy(busy), .ram_rw(ram_rw),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rw) ram[ram_addr] <= ram_din;
   end
   assign ram_dout = ram[ram_addr];

   // Model: one access = grant edge, completion edge one later, free again two edges after that.
   logic [DW-1:0] mmem [8];
   bit            m_active = 1'b0;
   int            m_age    = 0;
   int unsigned   m_ptr    = 1;
   int unsigned   m_w      = 0;
   bit            m_we     = 1'b0;
   logic [AW-1:0] m_addr   = '0;
   logic [DW-1:0] m_din    = '0;
   logic [DW-1:0] m_rdata  = '0;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_active = 1'b0; m_age = 0; m_ptr = 1; m_w = 0; m_we = 1'b0;
         m_addr = '0; m_din = '0; m_rdata = '0;
      end else if (m_active) begin
         m_age++;
         if (m_age == 1) begin
            if (m_we) mmem[m_addr] = m_din;
            else      m_rdata = mmem[m_addr];
            m_ptr = m_w;
         end else if (m_age == 2) begin
            m_active = 1'b0;
         end
      end else if (rq[0] || rq[1]) begin
         if (rq[0] && rq[1]) m_w = 1 - m_ptr;
         else                m_w = rq[0] ? 0 : 1;
         m_we     = rwe[m_w];
         m_addr   = raddr[m_w];
         m_din    = rwd[m_w];
         m_active = 1'b1;
         m_age    = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [1:0] eg;
      eg = !m_active ? 2'b00 : ((m_w == 0) ? 2'b01 : 2'b10);
      check("gnt",      gnt,      eg);
      check("busy",     busy,     m_active);
      check("ram_rw",   ram_rw,   m_active && m_age == 0 && m_we);
      check("ack0",     ack0,     m_active && m_age == 1 && m_w == 0);
      check("ack1",     ack1,     m_active && m_age == 1 && m_w == 1);
      check("ram_addr", ram_addr, m_addr);
      check("ram_din",  ram_din,  m_din);
      check("rdata",    rdata,    m_rdata);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic rand_fields(input int unsigned x);
      rwe[x]   = 1'($urandom_range(1));
      raddr[x] = AW'($urandom_range(7));
      rwd[x]   = DW'($urandom_range(16'hFFFF));
   endtask

   task automatic rand_drive(input int unsigned x);
      bit ackx, granted;
      ackx    = m_active && m_age == 1 && m_w == x;
      granted = m_active && m_w == x;
      if (rq[x] && ackx) begin
         rq[x] = ($urandom_range(3) == 0);
         if (rq[x]) rand_fields(x);
      end else if (!rq[x]) begin
         if ($urandom_range(2) == 0) begin
            rq[x] = 1'b1;
            rand_fields(x);
         end
      end else if (granted && $urandom_range(1) == 1) begin
         rand_fields(x);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rw"},    ram_rw,   1'b0);
      check({tag, "_gnt"},   gnt,      2'b00);
      check({tag, "_busy"},  busy,     1'b0);
      check({tag, "_ack0"},  ack0,     1'b0);
      check({tag, "_ack1"},  ack1,     1'b0);
      check({tag, "_addr"},  ram_addr, '0);
      check({tag, "_din"},   ram_din,  '0);
      check({tag, "_rdata"}, rdata,    '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] seq [4];
      seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int i = 0; i < 8; i++) begin ram[i] = '0; mmem[i] = '0; end
      for (int i = 0; i < 2; i++) begin rq[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0; end

      #1 clr = 1'b0;
      tick; check_reset_outputs("rst");
      tick; #1 clr = 1'b1;
      tick;

      // Single write from requester 0
      rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 3'd3; rwd[0] = 16'hBEEF;
      tick; check("t1_rw_c1", ram_rw, 1'b1); check("t1_gnt", gnt, 2'b01);
      tick; check("t1_ack0", ack0, 1'b1); check("t1_rw_c2", ram_rw, 1'b0); rq[0] = 1'b0;
      tick; check("t1_ack0_low", ack0, 1'b0); check("t1_ack1", ack1, 1'b0);
      check("t1_ram3", ram[3], 16'hBEEF);

      // Read back from requester 1
      rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 3'd3;
      tick;
      tick; check("t2_ack1", ack1, 1'b1); check("t2_rdata", rdata, 16'hBEEF); rq[1] = 1'b0;
      tick; tick; check("t2_rdata_held", rdata, 16'hBEEF);

      // Both writing addr 5 continuously
      rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 3'd5; rwd[0] = 16'h1111;
      rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 3'd5; rwd[1] = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         tick; check("t3_gnt_seq", gnt, seq[i]);
         tick; if (i == 3) begin rq[0] = 1'b0; rq[1] = 1'b0; end
         tick;
      end
      check("t3_ram5", ram[5], 16'h2222);

      // Tie right after reset
      #2 clr = 1'b0;
      tick; tick; #1 clr = 1'b1;
      tick;
      rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 3'd5;
      rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 3'd3;
      tick; check("t4_gnt_first", gnt, 2'b01);
      tick; check("t4_ack0", ack0, 1'b1); check("t4_rdata0", rdata, 16'h2222); rq[0] = 1'b0;
      tick;
      tick; check("t4_gnt_second", gnt, 2'b10);
      tick; check("t4_ack1", ack1, 1'b1); check("t4_rdata1", rdata, 16'hBEEF); rq[1] = 1'b0;
      tick;

      // Reset during a write access; pointer first moved to 0
      rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 3'd3;
      tick; tick; rq[0] = 1'b0;
      tick;
      rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 3'd2; rwd[1] = 16'hAAAA;
      tick; check("t5_rw", ram_rw, 1'b1); check("t5_gnt", gnt, 2'b10);
      #2 clr = 1'b0;
      #1 check_reset_outputs("t5_async");
      rq[1] = 1'b0;
      tick; #1 clr = 1'b1;
      tick;
      rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 3'd1;
      rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 3'd2;
      tick; check("t5_tie_gnt", gnt, 2'b01);
      tick; check("t5_ack0", ack0, 1'b1); rq[0] = 1'b0;
      tick;
      tick; check("t5_gnt1", gnt, 2'b10);
      tick; check("t5_ack1", ack1, 1'b1); check("t5_lost_write", rdata, 16'h0000); rq[1] = 1'b0;
      check("t5_ram2", ram[2], 16'h0000);
      tick;

      // Held read: one access every 3 cycles, one idle cycle between
      rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 3'd7;
      for (int j = 0; j < 12; j++) begin
         tick;
         check("t6_ack0_pattern", ack0, (j % 3) == 1);
         check("t6_busy_pattern", busy, (j % 3) != 2);
         if (j == 10) rq[0] = 1'b0;
      end

      // Random traffic with one mid-run reset
      for (int c = 0; c < 600; c++) begin
         tick;
         if (c == 300) begin
            #2 clr = 1'b0;
            #1 check_reset_outputs("rand_async");
            tick; #1 clr = 1'b1;
         end else begin
            rand_drive(0);
            rand_drive(1);
         end
      end
      rq[0] = 1'b0; rq[1] = 1'b0;
      repeat (4) tick;
      for (int i = 0; i < 8; i++) check("ram_final", ram[i], mmem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
